uart_tx_arbiter: RTL

Packet-level arbiter that shares the single `uart_tx` byte transmitter between two byte-stream requesters: port 0 carries drive commands from `command_translator`, port 1 carries low-rate telemetry (distance, pitch, direction reports). A grant is held for a whole packet, from the first byte to the byte flagged `last`, so messages never interleave on the link. Port 0 has priority. Port 1 is guaranteed service after a bounded number of port-0 packets. A stalled owner is evicted by an idle timeout. The block sits between the requesters and `uart_tx` in the top level, on the `clk_50` domain.

---
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-level arbiter sharing one uart_tx byte transmitter between drive commands (port 0)
// and telemetry (port 1). Grants are held per packet; port 1 gets a starvation guard and a stalled owner is evicted.
module uart_tx_arbiter #(
  parameter int MAX_SKIP     = 4,
  parameter int IDLE_TIMEOUT = 50000
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [1:0] grant,
  output logic [1:0] abort
);

  localparam int SW = (MAX_SKIP < 1) ? 1 : $clog2(MAX_SKIP + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT);
  localparam logic [SW-1:0] SKIP_MAX  = SW'(MAX_SKIP);
  localparam logic [TW-1:0] TIMER_END = TW'(IDLE_TIMEOUT - 1);

  // The state encoding doubles as the one-hot grant output.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t          state, state_next;
  logic [SW-1:0]   skip_cnt;
  logic [TW-1:0]   timer;
  logic [1:0]      abort_next;
  logic            own_valid;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    abort_next = 2'b00;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    s0_ready   = 1'b0;
    s1_ready   = 1'b0;
    own_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (s0_valid && s1_valid) state_next = (skip_cnt == SKIP_MAX) ? OWN1 : OWN0;
        else if (s0_valid)        state_next = OWN0;
        else if (s1_valid)        state_next = OWN1;
      end
      OWN0: begin
        tx_data   = s0_data;
        tx_valid  = s0_valid;
        s0_ready  = tx_ready;
        own_valid = s0_valid;
        if (s0_valid && tx_ready && s0_last) begin
          state_next = IDLE;
        end else if (!s0_valid && timer == TIMER_END) begin
          state_next = IDLE;
          abort_next = 2'b01;
        end
      end
      OWN1: begin
        tx_data   = s1_data;
        tx_valid  = s1_valid;
        s1_ready  = tx_ready;
        own_valid = s1_valid;
        if (s1_valid && tx_ready && s1_last) begin
          state_next = IDLE;
        end else if (!s1_valid && timer == TIMER_END) begin
          state_next = IDLE;
          abort_next = 2'b10;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; the asynchronous reset drops any partial packet.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      skip_cnt <= '0;
      timer    <= '0;
      abort    <= 2'b00;
    end else begin
      state <= state_next;
      abort <= abort_next;

      if (state == IDLE && state_next == OWN1)
        skip_cnt <= '0;
      else if (state == IDLE && state_next == OWN0 && s1_valid && skip_cnt != SKIP_MAX)
        skip_cnt <= skip_cnt + 1'b1;

      // Only owner-idle cycles age the timer; backpressure with valid held never does.
      if (state == IDLE || own_valid || state_next == IDLE)
        timer <= '0;
      else
        timer <= timer + 1'b1;
    end
  end

  assign grant = state;

endmodule
